// File: rtl/memu_burst.sv
// memu_burst: burst read/write controller over a 2**ADDR_WIDTH-word memory; `define MEMU_PARITY_EN adds per-word even parity and Parity_err.
// Latency: read beat k is valid READ_LATENCY+k cycles after the accepting edge; write beats land one per Data_in_valid edge.
// Backpressure: write beats stall on Data_in_valid=0 (Data_in_ready high in WR); read beats never stall; Req ignored while Busy.
module memu_burst #(
    parameter int WORD_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int BURST_WIDTH  = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   Req,
    input  logic                   Read_sig,
    input  logic                   Write_sig,
    input  logic [ADDR_WIDTH-1:0]  Address_in,
    input  logic [BURST_WIDTH-1:0] Burst_len,
    input  logic [WORD_WIDTH-1:0]  Data_in,
    input  logic                   Data_in_valid,
    output logic                   Data_in_ready,
    output logic [WORD_WIDTH-1:0]  Data_out,
    output logic                   Data_out_valid,
    output logic                   Busy,
    output logic                   Mem_op_success,
    output logic                   Mem_op_error
`ifdef MEMU_PARITY_EN
    ,
    output logic                   Parity_err
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_DRAIN = 3'd2;
    localparam logic [2:0] ST_WR       = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [BURST_WIDTH-1:0] len_q;
    logic [BURST_WIDTH-1:0] beat_q;
    logic                   err_q;

    logic [WORD_WIDTH-1:0]   mem [DEPTH];
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [WORD_WIDTH-1:0]   pipe_dat [READ_LATENCY];

    logic accept;
    logic issue;
    logic wr_beat;
    logic last_beat;
    logic drain_done;

    assign accept    = (state_q == ST_IDLE) && Req && (Read_sig ^ Write_sig);
    assign issue     = (state_q == ST_RD_ISSUE);
    assign wr_beat   = (state_q == ST_WR) && Data_in_valid;
    assign last_beat = (beat_q == len_q);

    // The final stage may still be presenting its beat as DONE is entered; all earlier stages must be empty.
    always_comb begin
        drain_done = 1'b1;
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
            if (pipe_vld[i]) drain_done = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept) state_d = Read_sig ? ST_RD_ISSUE : ST_WR;
            ST_RD_ISSUE: if (last_beat) state_d = ST_RD_DRAIN;
            ST_RD_DRAIN: if (drain_done) state_d = ST_DONE;
            ST_WR:       if (wr_beat && last_beat) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == ST_IDLE) && Req && (Read_sig == Write_sig);
            if (accept) begin
                addr_q <= Address_in;
                len_q  <= Burst_len;
                beat_q <= '0;
            end else if (issue || wr_beat) begin
                addr_q <= addr_q + 1'b1;
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    // Array is deliberately outside the reset domain so an aborted burst keeps what it already wrote.
    always_ff @(posedge Clk) begin
        if (wr_beat) mem[addr_q] <= Data_in;
    end

    // Each stage's data only moves with a valid beat, so the last stage holds the final beat.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_dat[i] <= '0;
        end else begin
            pipe_vld[0] <= issue;
            if (issue) pipe_dat[0] <= mem[addr_q];
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

`ifdef MEMU_PARITY_EN
    logic                    par_mem [DEPTH];
    logic [READ_LATENCY-1:0] pipe_par;

    always_ff @(posedge Clk) begin
        if (wr_beat) par_mem[addr_q] <= ^Data_in;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pipe_par <= '0;
        end else begin
            if (issue) pipe_par[0] <= par_mem[addr_q];
            for (int i = 1; i < READ_LATENCY; i++) begin
                if (pipe_vld[i-1]) pipe_par[i] <= pipe_par[i-1];
            end
        end
    end

    assign Parity_err = pipe_vld[READ_LATENCY-1] & ((^pipe_dat[READ_LATENCY-1]) ^ pipe_par[READ_LATENCY-1]);
`endif

    assign Busy           = (state_q != ST_IDLE);
    assign Data_in_ready  = (state_q == ST_WR);
    assign Data_out_valid = pipe_vld[READ_LATENCY-1];
    assign Data_out       = pipe_dat[READ_LATENCY-1];
    assign Mem_op_success = (state_q == ST_DONE);
    assign Mem_op_error   = err_q;

endmodule

// File: tb/tb_memu_burst.sv
// Directed bench for memu_burst: one instance at READ_LATENCY=1 and one at READ_LATENCY=3 share all inputs.
module tb_memu_burst;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Req, Read_sig, Write_sig;
    logic [7:0]  Address_in;
    logic [3:0]  Burst_len;
    logic [15:0] Data_in;
    logic        Data_in_valid;

    logic        a_rdy, a_dvld, a_busy, a_succ, a_err;
    logic [15:0] a_dout;
    logic        b_rdy, b_dvld, b_busy, b_succ, b_err;
    logic [15:0] b_dout;
`ifdef MEMU_PARITY_EN
    logic        a_perr, b_perr;
    bit          perr_en = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q [16];

    always #5 Clk = ~Clk;

    memu_burst dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Read_sig(Read_sig), .Write_sig(Write_sig),
        .Address_in(Address_in), .Burst_len(Burst_len), .Data_in(Data_in), .Data_in_valid(Data_in_valid),
        .Data_in_ready(a_rdy), .Data_out(a_dout), .Data_out_valid(a_dvld), .Busy(a_busy),
        .Mem_op_success(a_succ), .Mem_op_error(a_err)
`ifdef MEMU_PARITY_EN
        , .Parity_err(a_perr)
`endif
    );

    memu_burst #(.READ_LATENCY(3)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Read_sig(Read_sig), .Write_sig(Write_sig),
        .Address_in(Address_in), .Burst_len(Burst_len), .Data_in(Data_in), .Data_in_valid(Data_in_valid),
        .Data_in_ready(b_rdy), .Data_out(b_dout), .Data_out_valid(b_dvld), .Busy(b_busy),
        .Mem_op_success(b_succ), .Mem_op_error(b_err)
`ifdef MEMU_PARITY_EN
        , .Parity_err(b_perr)
`endif
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Writes nb beats from exp_q; abort_after>=0 pulls Reset_n low before that beat.
    task automatic do_write(input logic [7:0] addr, input int nb, input int abort_after, input bit stall);
        @(negedge Clk);
        Req = 1'b1; Write_sig = 1'b1; Read_sig = 1'b0;
        Address_in = addr; Burst_len = 4'(nb - 1);
        @(negedge Clk);
        Req = 1'b0; Write_sig = 1'b0;
        chk1("wr_busy_a", a_busy, 1'b1);
        chk1("wr_rdy_a", a_rdy, 1'b1);
        chk1("wr_rdy_b", b_rdy, 1'b1);
        for (int k = 0; k < nb; k++) begin
            if (k == abort_after) begin
                Data_in_valid = 1'b0;
                Reset_n = 1'b0;
                #1;
                chk1("rst_busy_a", a_busy, 1'b0);
                chk1("rst_rdy_a", a_rdy, 1'b0);
                chk1("rst_dvld_a", a_dvld, 1'b0);
                chk16("rst_dout_b", b_dout, 16'h0000);
                @(negedge Clk);
                Reset_n = 1'b1;
                @(negedge Clk);
                return;
            end
            if (stall && k == 1) begin
                Data_in_valid = 1'b0;
                @(negedge Clk);
                chk1("stall_rdy_a", a_rdy, 1'b1);
                chk1("stall_succ_a", a_succ, 1'b0);
            end
            Data_in = exp_q[k];
            Data_in_valid = 1'b1;
            @(negedge Clk);
        end
        Data_in_valid = 1'b0;
        chk1("wr_succ_a", a_succ, 1'b1);
        chk1("wr_succ_b", b_succ, 1'b1);
        chk1("wr_done_rdy_a", a_rdy, 1'b0);
        @(negedge Clk);
        chk1("wr_succ_end_a", a_succ, 1'b0);
        chk1("wr_idle_a", a_busy, 1'b0);
        chk1("wr_idle_b", b_busy, 1'b0);
    endtask

    // Reads nb beats and checks exact beat timing for both latencies against exp_q.
    task automatic do_read(input logic [7:0] addr, input int nb);
        int sa, sb, ne;
        logic ev;
        sa = 0; sb = 0; ne = 0;
        @(negedge Clk);
        Req = 1'b1; Read_sig = 1'b1; Write_sig = 1'b0;
        Address_in = addr; Burst_len = 4'(nb - 1);
        for (int j = 0; j <= nb + 5; j++) begin
            @(negedge Clk);
            if (j == 0) begin
                Read_sig = 1'b1; Write_sig = 1'b1;
            end else begin
                Req = 1'b0; Read_sig = 1'b0; Write_sig = 1'b0;
            end
            ev = (j >= 1) && (j <= nb);
            chk1("rd_vld_a", a_dvld, ev);
            if (ev) chk16("rd_dat_a", a_dout, exp_q[j-1]);
`ifdef MEMU_PARITY_EN
            chk1("rd_perr_a", a_perr, ev && perr_en);
`endif
            ev = (j >= 3) && (j <= nb + 2);
            chk1("rd_vld_b", b_dvld, ev);
            if (ev) chk16("rd_dat_b", b_dout, exp_q[j-3]);
`ifdef MEMU_PARITY_EN
            chk1("rd_perr_b", b_perr, ev && perr_en);
`endif
            if (a_succ) sa++;
            if (b_succ) sb++;
            if (a_err || b_err) ne++;
        end
        chkn("rd_succ_cnt_a", sa, 1);
        chkn("rd_succ_cnt_b", sb, 1);
        chkn("rd_err_cnt", ne, 0);
        chk16("rd_hold_a", a_dout, exp_q[nb-1]);
        chk16("rd_hold_b", b_dout, exp_q[nb-1]);
        chk1("rd_idle_a", a_busy, 1'b0);
        chk1("rd_idle_b", b_busy, 1'b0);
    endtask

    initial begin
        Reset_n = 1'b0; Req = 1'b0; Read_sig = 1'b0; Write_sig = 1'b0;
        Address_in = '0; Burst_len = '0; Data_in = '0; Data_in_valid = 1'b0;
        repeat (3) @(negedge Clk);
        chk1("reset_busy_a", a_busy, 1'b0);
        chk1("reset_rdy_a", a_rdy, 1'b0);
        chk1("reset_dvld_a", a_dvld, 1'b0);
        chk1("reset_succ_a", a_succ, 1'b0);
        chk1("reset_err_a", a_err, 1'b0);
        chk16("reset_dout_a", a_dout, 16'h0000);
        chk1("reset_busy_b", b_busy, 1'b0);
        chk1("reset_dvld_b", b_dvld, 1'b0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // 4-beat write/read at 0x10, with a one-cycle write stall
        for (int k = 0; k < 4; k++) exp_q[k] = 16'hA001 + 16'(k);
        do_write(8'h10, 4, -1, 1'b1);
        do_read(8'h10, 4);

        // Address wrap at the top of memory
        exp_q[0] = 16'h1111; exp_q[1] = 16'h2222; exp_q[2] = 16'h3333;
        do_write(8'hFE, 3, -1, 1'b0);
        do_read(8'hFE, 3);
        exp_q[0] = 16'h3333;
        do_read(8'h00, 1);

        // Illegal command: single error pulse, no busy, memory untouched
        @(negedge Clk);
        Req = 1'b1; Read_sig = 1'b1; Write_sig = 1'b1; Address_in = 8'h10; Burst_len = 4'd0;
        Data_in = 16'hDEAD; Data_in_valid = 1'b1;
        @(negedge Clk);
        Req = 1'b0; Read_sig = 1'b0; Write_sig = 1'b0; Data_in_valid = 1'b0;
        chk1("ill_err_a", a_err, 1'b1);
        chk1("ill_err_b", b_err, 1'b1);
        chk1("ill_busy_a", a_busy, 1'b0);
        @(negedge Clk);
        chk1("ill_err_end_a", a_err, 1'b0);
        chk1("ill_busy_end_a", a_busy, 1'b0);
        for (int k = 0; k < 4; k++) exp_q[k] = 16'hA001 + 16'(k);
        do_read(8'h10, 4);

        // Reset mid-burst keeps the two beats already written
        for (int k = 0; k < 4; k++) exp_q[k] = 16'hC001 + 16'(k);
        do_write(8'h20, 4, -1, 1'b0);
        for (int k = 0; k < 4; k++) exp_q[k] = 16'hB001 + 16'(k);
        do_write(8'h20, 4, 2, 1'b0);
        exp_q[0] = 16'hB001; exp_q[1] = 16'hB002; exp_q[2] = 16'hC003; exp_q[3] = 16'hC004;
        do_read(8'h20, 4);

        // Maximum burst length crossing the wrap point
        for (int k = 0; k < 16; k++) exp_q[k] = 16'h5000 + 16'(k * 3);
        do_write(8'hF8, 16, -1, 1'b0);
        do_read(8'hF8, 16);

`ifdef MEMU_PARITY_EN
        exp_q[0] = 16'h0F0F;
        do_write(8'h05, 1, -1, 1'b0);
        do_read(8'h05, 1);
        dut_a.mem[5][3] = ~dut_a.mem[5][3];
        dut_b.mem[5][3] = ~dut_b.mem[5][3];
        exp_q[0] = 16'h0F07;
        perr_en = 1'b1;
        do_read(8'h05, 1);
        perr_en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memu_burst.md
MEMU_BURST -- requirements
Module: memu_burst

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, word address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter BURST_WIDTH, default 4, width of Burst_len; max burst = 2**BURST_WIDTH beats.
REQ-004 SHALL have parameter READ_LATENCY, default 1, legal 1..4, cycles from read-address issue to Data_out_valid.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of Clk.
REQ-006 Port: Clk  input  1  system clock.
REQ-007 Port: Reset_n  input  1  asynchronous active-low reset.
REQ-008 Port: Req  input  1  operation request, sampled on the Clk rising edge.
REQ-009 Port: Read_sig  input  1  read command qualifier.
REQ-010 Port: Write_sig  input  1  write command qualifier.
REQ-011 Port: Address_in  input  ADDR_WIDTH  start word address.
REQ-012 Port: Burst_len  input  BURST_WIDTH  beat count minus one.
REQ-013 Port: Data_in  input  WORD_WIDTH  write data beat.
REQ-014 Port: Data_in_valid  input  1  write beat valid.
REQ-015 Port: Data_in_ready  output  1  write beat accepted when high together with Data_in_valid.
REQ-016 Port: Data_out  output  WORD_WIDTH  read data beat.
REQ-017 Port: Data_out_valid  output  1  read beat valid, one cycle per beat.
REQ-018 Port: Busy  output  1  high whenever the state is not IDLE.
REQ-019 Port: Mem_op_success  output  1  one-cycle completion pulse.
REQ-020 Port: Mem_op_error  output  1  one-cycle illegal-command pulse.

Function
REQ-021 SHALL implement the states IDLE, RD_ISSUE, RD_DRAIN, WR and DONE.
REQ-022 SHALL accept a request at edge N only if the state is IDLE, Req=1 and exactly one of Read_sig and Write_sig is 1; at that edge it SHALL latch Address_in and Burst_len.
REQ-023 SHALL ignore a Req with Read_sig==Write_sig in IDLE, keep the state, and pulse Mem_op_error for the single cycle after edge N.
REQ-024 SHALL ignore Req while Busy=1, with no error pulse.
REQ-025 Read: in RD_ISSUE the block SHALL issue one address per cycle, incrementing it; after the last beat it SHALL go to RD_DRAIN until the latency pipeline is empty, then to DONE.
REQ-026 Read beat k SHALL appear with Data_out_valid=1 in the cycle following edge N+k+READ_LATENCY, with beats consecutive and no gaps.
REQ-027 Write: in WR, Data_in_ready SHALL be 1; each edge with Data_in_valid=1 SHALL write Data_in to the current address and increment it; after the final beat the block SHALL go to DONE.
REQ-028 Write beats SHALL stall indefinitely while Data_in_valid=0, with no timeout.
REQ-029 DONE SHALL last exactly one cycle with Mem_op_success=1, then return to IDLE; the earliest next acceptance is the edge ending DONE+1.
REQ-030 The address SHALL wrap from 2**ADDR_WIDTH-1 to 0 within a burst.
REQ-031 A read issued after a completed write to the same address SHALL return the new data.
REQ-032 Data_out SHALL hold the last read beat when Data_out_valid=0.

Reset
REQ-033 While Reset_n=0 the block SHALL be in IDLE with Busy, Data_in_ready, Data_out_valid, Mem_op_success and Mem_op_error at 0, Data_out at 0, and the latency pipeline cleared.
REQ-034 Reset asserted mid-burst SHALL abort the operation with no further writes; words already written SHALL be retained.
REQ-035 Memory array contents SHALL NOT be initialised by reset.

Configuration
REQ-036 With MEMU_PARITY_EN defined, the block SHALL store an even-parity bit per word, check it on every read beat, and add output Parity_err (1 bit), equal to 1 with the offending Data_out_valid beat; without the macro, no parity storage, no check and no Parity_err port SHALL exist.

Verification
REQ-037 The bench SHALL write 4 beats at 0x10 (Burst_len=3, data 0xA001..0xA004), then read 4 beats from 0x10, and require data 0xA001..0xA004 and one Mem_op_success per operation.
REQ-038 The bench SHALL write 3 beats at 0xFE (0x1111, 0x2222, 0x3333), then read 1 beat at 0x00, and require 0x3333 (wrap).
REQ-039 The bench SHALL run with READ_LATENCY=3 and a read at 0x10 accepted at edge N, and require the first Data_out_valid after edge N+3 and 4 consecutive beats.
REQ-040 The bench SHALL assert Req with Read_sig=Write_sig=1, and require a one-cycle Mem_op_error, Busy=0 and no memory change.
REQ-041 The bench SHALL assert Reset_n=0 after 2 of 4 write beats to 0x20 (0xB001..0xB004), and require that a read of 0x20..0x23 returns 0xB001 and 0xB002 followed by the prior contents.
REQ-042 The bench SHALL, with MEMU_PARITY_EN defined, force-flip one stored bit at 0x05 and read it, and require Parity_err=1 with that beat.
